seg_scan_capture: RTL and testbench

- Passive receiver for the multiplexed seven-segment display bus (segments plus anodes) driven by the top-level display controller.
- Watches the scan and waits for each digit's pattern to settle, then decodes it back to a hex nibble.
- Assembles the four digits into a 16-bit word and reports one frame per complete scan.
- Sits beside the display driver as an on-chip readback/self-check path, and is reused in benches as the display scoreboard.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg7_to_hex.sv | 40 ++++
 rtl/seg_scan_capture.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Seven-segment codes, anode patterns and digit-count constants,
//            shared by the display driver and the scan capture path.
// Revision : 1.0
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode enables, bit0 = rightmost digit
    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    // Active-low segment codes, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
// Module   : seg7_to_hex
// Brief    : Combinational decode of an active-low segment pattern to a nibble.
// Revision : 1.0
// ============================================================================
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] segDisplay,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (segDisplay)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture
// Brief    : Passive readback of a multiplexed 7-segment scan into 16-bit frames.
// Revision : 1.0
// ============================================================================
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STALL_CYCLES  = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segDisplay,
    input  logic [3:0]  anDisplay,
    output logic [15:0] capturedValue,
    output logic        frameValid,
    output logic [3:0]  digitErr,
    output logic        scanStalled
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_HELD   = 1'b1;

    logic [3:0]         an_r;
    logic [6:0]         seg_r;
    logic [CNT_W-1:0]   stable_cnt;
    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               same;
    logic               commit;
    logic               an_ok;
    digit_idx_t         dig_idx;
    logic [3:0]         digit_mask;
    logic               dec_valid;
    logic [3:0]         dec_nibble;
    logic [15:0]        nibbles;
    logic [15:0]        nib_upd;
    logic [3:0]         err_acc;
    logic [3:0]         err_upd;
    logic [3:0]         seen;
    logic [3:0]         seen_upd;
    logic [STALL_W-1:0] stall_tmr;
    logic               frame_pend;
    logic               valid_commit;

    seg7_to_hex u_dec (
        .segDisplay (seg_r),
        .valid      (dec_valid),
        .nibble     (dec_nibble)
    );

    // The incoming port value is the "new sample"; the held register is the previous one
    assign same = ({anDisplay, segDisplay} == {an_r, seg_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!same) begin
            state_next = ST_SETTLE;
        end else if (state == ST_SETTLE && stable_cnt == CNT_COMMIT) begin
            state_next = ST_HELD;
        end
    end

    always_comb begin
        commit = (state == ST_SETTLE) && same && (stable_cnt == CNT_COMMIT);
    end

    always_comb begin
        an_ok   = 1'b1;
        dig_idx = 2'd0;
        case (an_r)
            AN_D0:   dig_idx = 2'd0;
            AN_D1:   dig_idx = 2'd1;
            AN_D2:   dig_idx = 2'd2;
            AN_D3:   dig_idx = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    assign valid_commit = commit && an_ok;
    assign digit_mask   = 4'b0001 << dig_idx;
    assign seen_upd     = seen | digit_mask;
    assign err_upd      = (err_acc & ~digit_mask) | (dec_valid ? 4'b0000 : digit_mask);

    always_comb begin
        nib_upd = nibbles;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_mask[i] && dec_valid) begin
                nib_upd[4*i +: 4] = dec_nibble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r          <= 4'b1111;
            seg_r         <= SEG_BLANK;
            stable_cnt    <= '0;
            stall_tmr     <= '0;
            nibbles       <= '0;
            err_acc       <= '0;
            seen          <= '0;
            frame_pend    <= 1'b0;
            frameValid    <= 1'b0;
            capturedValue <= '0;
            digitErr      <= '0;
        end else begin
            an_r  <= anDisplay;
            seg_r <= segDisplay;

            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end

            if (valid_commit) begin
                stall_tmr <= '0;
            end else if (stall_tmr != STALL_MAX) begin
                stall_tmr <= stall_tmr + 1'b1;
            end

            // Outputs trail the completing commit by one edge; nibbles already hold it
            frameValid <= frame_pend;
            frame_pend <= 1'b0;
            if (frame_pend) begin
                capturedValue <= nibbles;
                digitErr      <= err_acc;
            end

            if (valid_commit) begin
                nibbles <= nib_upd;
                err_acc <= err_upd;
                if (seen_upd == 4'b1111) begin
                    seen       <= '0;
                    frame_pend <= 1'b1;
                end else begin
                    seen <= seen_upd;
                end
            end
        end
    end

    assign scanStalled = (stall_tmr == STALL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_capture
// Brief    : Directed and random scans checked against a run-length reference model.
// Revision : 1.0
// ============================================================================
module tb_seg_scan_capture;

    localparam int STABLE = 4;
    localparam int STALL  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] capturedValue;
    logic        frameValid;
    logic [3:0]  digitErr;
    logic        scanStalled;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .STABLE_CYCLES (STABLE),
        .STALL_CYCLES  (STALL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .segDisplay    (seg),
        .anDisplay     (an),
        .capturedValue (capturedValue),
        .frameValid    (frameValid),
        .digitErr      (digitErr),
        .scanStalled   (scanStalled)
    );

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int total = 0;
    int bad   = 0;
    int frames = 0;

    // Reference model: a commit is the edge at which the port value has been
    // identical for STABLE+1 consecutive edges.
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_nib;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    int          m_since;
    bit          pend;
    logic [15:0] pend_cap;
    logic [3:0]  pend_err;
    logic        e_fv;
    logic [15:0] e_cap;
    logic [3:0]  e_err;
    logic [6:0]  last_seg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dec_code(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        logic [3:0] oh;
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            if (a == ~oh) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        return ~oh;
    endfunction

    task automatic model_edge();
        logic [10:0] cur;
        int d;
        int v;
        if (rst) begin
            m_prev = {4'hF, 7'h7F}; m_run = 1; m_nib = '0; m_err = '0; m_seen = '0;
            m_since = 0; pend = 0; e_fv = 0; e_cap = '0; e_err = '0;
        end else begin
            e_fv = pend;
            if (pend) begin
                e_cap = pend_cap;
                e_err = pend_err;
            end
            pend = 0;
            cur = {an, seg};
            if (cur == m_prev) begin
                if (m_run < STABLE + 2) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = cur;
            if (m_since < STALL) m_since++;
            if (m_run == STABLE + 1) begin
                d = an_idx(an);
                if (d >= 0) begin
                    v = dec_code(seg);
                    m_since = 0;
                    m_seen[d] = 1'b1;
                    if (v >= 0) begin
                        m_nib[4*d +: 4] = 4'(v);
                        m_err[d] = 1'b0;
                    end else begin
                        m_err[d] = 1'b1;
                    end
                    if (m_seen == 4'hF) begin
                        pend = 1; pend_cap = m_nib; pend_err = m_err; m_seen = '0;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] a, input logic [6:0] s);
        an = a;
        seg = s;
        @(posedge clk);
        model_edge();
        #1;
        check("frameValid", 32'(frameValid), 32'(e_fv));
        check("capturedValue", 32'(capturedValue), 32'(e_cap));
        check("digitErr", 32'(digitErr), 32'(e_err));
        check("scanStalled", 32'(scanStalled), 32'(m_since == STALL));
        if (frameValid) frames++;
    endtask

    task automatic dwell(input int d, input logic [6:0] code, input int n, input bit glitch);
        for (int k = 0; k < n; k++) tick(an_of(d), (glitch && k == 0) ? last_seg : code);
        last_seg = code;
    endtask

    task automatic scan(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                        input logic [6:0] c3, input int n, input bit glitch);
        dwell(0, c0, n, glitch);
        dwell(1, c1, n, glitch);
        dwell(2, c2, n, glitch);
        dwell(3, c3, n, glitch);
    endtask

    initial begin
        int f0;
        logic [3:0]  v [4];
        logic [15:0] exp_val;
        int d;
        logic [6:0] s;
        logic [3:0] a;

        rst = 1'b1;
        an = 4'hF;
        seg = 7'h7F;
        last_seg = 7'h7F;
        for (int i = 0; i < 3; i++) tick(4'hF, 7'h7F);
        rst = 1'b0;

        // Plain scan
        f0 = frames;
        scan(7'h12, 7'h24, 7'h30, 7'h19, 8, 1'b0);
        check("scan1_frames", 32'(frames - f0), 32'd1);
        check("scan1_value", 32'(capturedValue), 32'h4325);
        check("scan1_err", 32'(digitErr), 32'h0);

        // Stale segment data for one cycle after each anode change
        f0 = frames;
        scan(7'h12, 7'h24, 7'h30, 7'h19, 8, 1'b1);
        check("glitch_frames", 32'(frames - f0), 32'd1);
        check("glitch_value", 32'(capturedValue), 32'h4325);
        check("glitch_err", 32'(digitErr), 32'h0);

        // Blank digit 2 keeps its previous nibble and flags an error
        f0 = frames;
        scan(7'h12, 7'h24, 7'h7F, 7'h19, 8, 1'b0);
        check("blank_frames", 32'(frames - f0), 32'd1);
        check("blank_value", 32'(capturedValue), 32'h4325);
        check("blank_err", 32'(digitErr), 32'h4);

        // No commit from 1111, none from a 4-cycle dwell, one from a 5-cycle dwell
        f0 = frames;
        for (int i = 0; i < 10; i++) tick(4'hF, 7'h40);
        dwell(1, 7'h02, 4, 1'b0);
        dwell(0, 7'h06, 5, 1'b0);
        dwell(2, 7'h30, 8, 1'b0);
        dwell(3, 7'h19, 8, 1'b0);
        check("short_dwell_noframe", 32'(frames - f0), 32'd0);
        dwell(1, 7'h24, 8, 1'b0);
        check("short_dwell_frames", 32'(frames - f0), 32'd1);
        check("short_dwell_value", 32'(capturedValue), 32'h432E);
        check("short_dwell_err", 32'(digitErr), 32'h0);

        // Frozen bus: the last commit was 3 edges before the dwell ended
        dwell(1, 7'h24, 46, 1'b0);
        check("stall_before", 32'(scanStalled), 32'd0);
        dwell(1, 7'h24, 1, 1'b0);
        check("stall_rise", 32'(scanStalled), 32'd1);
        dwell(1, 7'h24, 10, 1'b0);
        dwell(2, 7'h30, 4, 1'b0);
        check("stall_held", 32'(scanStalled), 32'd1);
        dwell(2, 7'h30, 1, 1'b0);
        check("stall_fall", 32'(scanStalled), 32'd0);
        dwell(2, 7'h30, 3, 1'b0);

        // Reset mid-frame, then a fresh random frame
        dwell(0, 7'h40, 8, 1'b0);
        dwell(1, 7'h79, 8, 1'b0);
        dwell(3, 7'h10, 8, 1'b0);
        rst = 1'b1;
        tick(an_of(3), 7'h10);
        tick(an_of(3), 7'h10);
        rst = 1'b0;
        check("rst_value", 32'(capturedValue), 32'h0);
        for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
        exp_val = {v[3], v[2], v[1], v[0]};
        f0 = frames;
        dwell(0, codes[v[0]], 8, 1'b0);
        dwell(1, codes[v[1]], 8, 1'b0);
        dwell(2, codes[v[2]], 8, 1'b0);
        check("rst_partial", 32'(frames - f0), 32'd0);
        dwell(3, codes[v[3]], 8, 1'b0);
        check("rst_frames", 32'(frames - f0), 32'd1);
        check("rst_frame_value", 32'(capturedValue), 32'(exp_val));

        // Random scan traffic
        for (int n = 0; n < 60; n++) begin
            d = $urandom_range(0, 5);
            a = (d < 4) ? an_of(d) : ((d == 4) ? 4'hF : 4'hC);
            s = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 15)] : 7'($urandom);
            for (int k = $urandom_range(1, 8); k > 0; k--) begin
                tick(a, ($urandom_range(0, 3) == 0 && k == 1) ? last_seg : s);
            end
            last_seg = s;
        end
        for (int i = 0; i < 4; i++) tick(4'hF, 7'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
